// File: rtl/pb_press_detect.sv
// Press-side push-button front end: synchronizes and debounces active-low PB, emits press pulses,
// a long-hold level and, when PB_REPEAT_EN is defined, auto-repeat pulses on rpt_pulse.
module pb_press_detect #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned HOLD_CYCLES     = 1000,
  parameter int unsigned REPEAT_CYCLES   = 250,
  parameter int unsigned CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic PB,
  output logic pb_clean,
  output logic pressed,
  output logic held,
  // "repeat" is a reserved word, so the auto-repeat pulse carries this name instead
  output logic rpt_pulse
);

  if (DEBOUNCE_CYCLES < 2 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 2 ||
      (DEBOUNCE_CYCLES >> CNT_W) != 0 || (HOLD_CYCLES >> CNT_W) != 0 ||
      (REPEAT_CYCLES >> CNT_W) != 0) begin : g_param_check
    $error("pb_press_detect: illegal parameter combination");
  end

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StPressDb = 3'd1,
    StDown    = 3'd2,
    StHold    = 3'd3,
    StRelDb   = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] DbLast   = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HoldLast = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CntMax   = '1;
`ifdef PB_REPEAT_EN
  localparam logic [CNT_W-1:0] RepLast  = CNT_W'(REPEAT_CYCLES - 1);
`endif

  logic             s1_q, pbs_q;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             from_hold_q, from_hold_d;
  logic             press_ev_q, press_ev_d;
  logic             pb_clean_q, pb_clean_d;
  logic             pressed_q;
  logic             held_q, held_d;
`ifdef PB_REPEAT_EN
  logic             rep_ev_q, rep_ev_d;
  logic             rpt_q;
`endif

  assign cnt_inc = (cnt_q == CntMax) ? cnt_q : cnt_q + CNT_W'(1);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    from_hold_d = from_hold_q;
    press_ev_d  = 1'b0;
`ifdef PB_REPEAT_EN
    rep_ev_d    = 1'b0;
`endif
    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!pbs_q) begin
          state_d = StPressDb;
          cnt_d   = CNT_W'(1);
        end
      end
      StPressDb: begin
        if (pbs_q) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (cnt_q == DbLast) begin
          state_d    = StDown;
          cnt_d      = '0;
          press_ev_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StDown: begin
        if (pbs_q) begin
          state_d     = StRelDb;
          cnt_d       = CNT_W'(1);
          from_hold_d = 1'b0;
        end else if (cnt_q == HoldLast) begin
          state_d  = StHold;
          cnt_d    = '0;
`ifdef PB_REPEAT_EN
          rep_ev_d = 1'b1;
`endif
        end else begin
          cnt_d = cnt_inc;
        end
      end
      StHold: begin
        if (pbs_q) begin
          state_d     = StRelDb;
          cnt_d       = CNT_W'(1);
          from_hold_d = 1'b1;
        end else begin
`ifdef PB_REPEAT_EN
          if (cnt_q == RepLast) begin
            cnt_d    = '0;
            rep_ev_d = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
`else
          cnt_d = '0;
`endif
        end
      end
      StRelDb: begin
        if (!pbs_q) begin
          // Release bounce: resume where we were, restarting that state's timer
          state_d = from_hold_q ? StHold : StDown;
          cnt_d   = '0;
        end else if (cnt_q == DbLast) begin
          state_d     = StIdle;
          cnt_d       = '0;
          from_hold_d = 1'b0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d     = StIdle;
        cnt_d       = '0;
        from_hold_d = 1'b0;
      end
    endcase
  end

  // Outputs are decoded from registered state and registered once more
  always_comb begin
    pb_clean_d = (state_q == StIdle) || (state_q == StPressDb);
    held_d     = (state_q == StHold) || ((state_q == StRelDb) && from_hold_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q        <= 1'b1;
      pbs_q       <= 1'b1;
      state_q     <= StIdle;
      cnt_q       <= '0;
      from_hold_q <= 1'b0;
      press_ev_q  <= 1'b0;
      pb_clean_q  <= 1'b1;
      pressed_q   <= 1'b0;
      held_q      <= 1'b0;
    end else begin
      s1_q        <= PB;
      pbs_q       <= s1_q;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      from_hold_q <= from_hold_d;
      press_ev_q  <= press_ev_d;
      pb_clean_q  <= pb_clean_d;
      pressed_q   <= press_ev_q;
      held_q      <= held_d;
    end
  end

`ifdef PB_REPEAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rep_ev_q <= 1'b0;
      rpt_q    <= 1'b0;
    end else begin
      rep_ev_q <= rep_ev_d;
      rpt_q    <= rep_ev_q;
    end
  end

  assign rpt_pulse = rpt_q;
`else
  assign rpt_pulse = 1'b0;
`endif

  assign pb_clean = pb_clean_q;
  assign pressed  = pressed_q;
  assign held     = held_q;

endmodule

// File: tb/tb_pb_press_detect.sv
// Directed bench for pb_press_detect (N=4, HOLD=20, REPEAT=5); repeat expectations follow
// PB_REPEAT_EN.
module tb_pb_press_detect;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic PB  = 1'b1;
  logic pb_clean, pressed, held, rpt_pulse;

  int checks   = 0;
  int failures = 0;
  int ecnt     = 0;
  int base, b2;
  int press_q[$], rep_q[$], hrise_q[$], hfall_q[$], cfall_q[$], crise_q[$];
  logic held_p  = 1'b0;
  logic clean_p = 1'b1;

  pb_press_detect #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (20),
    .REPEAT_CYCLES  (5),
    .CNT_W          (20)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .PB       (PB),
    .pb_clean (pb_clean),
    .pressed  (pressed),
    .held     (held),
    .rpt_pulse(rpt_pulse)
  );

  always #5 clk = ~clk;

  // Event recorder: edge index at which each output event became visible
  always @(posedge clk) begin
    ecnt++;
    #1;
    if (pressed) press_q.push_back(ecnt);
    if (rpt_pulse) rep_q.push_back(ecnt);
    if (held && !held_p) hrise_q.push_back(ecnt);
    if (!held && held_p) hfall_q.push_back(ecnt);
    if (!pb_clean && clean_p) cfall_q.push_back(ecnt);
    if (pb_clean && !clean_p) crise_q.push_back(ecnt);
    held_p  = held;
    clean_p = pb_clean;
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_ev();
    press_q.delete();
    rep_q.delete();
    hrise_q.delete();
    hfall_q.delete();
    cfall_q.delete();
    crise_q.delete();
  endtask

  function automatic int rel(input int q[$], input int i, input int b);
    return (i < q.size()) ? q[i] - b : -1;
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    cycles(2);
    check_eq("rst_pb_clean", int'(pb_clean), 1);
    check_eq("rst_pressed", int'(pressed), 0);
    check_eq("rst_held", int'(held), 0);
    check_eq("rst_repeat", int'(rpt_pulse), 0);

    // Reset in the middle of press debounce
    rst = 1'b0;
    PB  = 1'b0;
    cycles(3);
    #2 rst = 1'b1;
    #1;
    check_eq("rst_mid_db_pb_clean", int'(pb_clean), 1);
    check_eq("rst_mid_db_pressed", int'(pressed), 0);
    check_eq("rst_mid_db_held", int'(held), 0);
    check_eq("rst_mid_db_repeat", int'(rpt_pulse), 0);
    @(negedge clk);
    rst = 1'b0;
    clear_ev();
    base = ecnt + 1;
    cycles(9);
    check_eq("post_rst_press_cnt", press_q.size(), 1);
    check_eq("post_rst_press_edge", rel(press_q, 0, base), 6);
    check_eq("post_rst_pb_clean_low", int'(pb_clean), 0);

    // Reset while the button is accepted as down
    #2 rst = 1'b1;
    #1;
    check_eq("rst_mid_down_pb_clean", int'(pb_clean), 1);
    @(negedge clk);
    rst = 1'b0;
    PB  = 1'b1;
    cycles(4);

    // Clean press of 10 cycles
    clear_ev();
    base = ecnt + 1;
    PB   = 1'b0;
    cycles(10);
    b2 = ecnt + 1;
    PB = 1'b1;
    cycles(12);
    check_eq("clean_press_cnt", press_q.size(), 1);
    check_eq("clean_press_edge", rel(press_q, 0, base), 6);
    check_eq("clean_fall_edge", rel(cfall_q, 0, base), 6);
    check_eq("clean_rise_edge", rel(crise_q, 0, b2), 6);
    check_eq("clean_held_cnt", hrise_q.size(), 0);
    check_eq("clean_repeat_cnt", rep_q.size(), 0);

    // Bounce: every low run shorter than the debounce window
    clear_ev();
    PB = 1'b0;
    cycles(3);
    PB = 1'b1;
    cycles(2);
    PB = 1'b0;
    cycles(3);
    PB = 1'b1;
    cycles(12);
    check_eq("bounce_press_cnt", press_q.size(), 0);
    check_eq("bounce_clean_fall_cnt", cfall_q.size(), 0);
    check_eq("bounce_pb_clean", int'(pb_clean), 1);

    // Long hold of 60 cycles
    clear_ev();
    base = ecnt + 1;
    PB   = 1'b0;
    cycles(60);
    b2 = ecnt + 1;
    PB = 1'b1;
    cycles(12);
    check_eq("long_press_cnt", press_q.size(), 1);
    check_eq("long_press_edge", rel(press_q, 0, base), 6);
    check_eq("long_held_rise_cnt", hrise_q.size(), 1);
    check_eq("long_held_rise_edge", rel(hrise_q, 0, base), 26);
    check_eq("long_held_fall_edge", rel(hfall_q, 0, b2), 6);
    check_eq("long_clean_rise_edge", rel(crise_q, 0, b2), 6);
`ifdef PB_REPEAT_EN
    check_eq("long_repeat_cnt", rep_q.size(), 8);
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("long_repeat_edge%0d", i), rel(rep_q, i, base), 26 + 5 * i);
    end
`else
    check_eq("long_repeat_cnt", rep_q.size(), 0);
`endif

    // Release bounce while in HOLD
    clear_ev();
    base = ecnt + 1;
    PB   = 1'b0;
    cycles(40);
    PB = 1'b1;
    cycles(2);
    PB = 1'b0;
    cycles(20);
    b2 = ecnt + 1;
    PB = 1'b1;
    cycles(12);
    check_eq("relb_press_cnt", press_q.size(), 1);
    check_eq("relb_held_rise_cnt", hrise_q.size(), 1);
    check_eq("relb_held_fall_cnt", hfall_q.size(), 1);
    check_eq("relb_held_fall_edge", rel(hfall_q, 0, b2), 6);
    begin
`ifdef PB_REPEAT_EN
      int exp_rep[7];
      exp_rep = '{26, 31, 36, 41, 50, 55, 60};
      check_eq("relb_repeat_cnt", rep_q.size(), 7);
      for (int i = 0; i < 7; i++) begin
        check_eq($sformatf("relb_repeat_edge%0d", i), rel(rep_q, i, base), exp_rep[i]);
      end
`else
      check_eq("relb_repeat_cnt", rep_q.size(), 0);
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
